puf_challenge_ctrl: RTL and testbench
=====================================

Name: puf_challenge_ctrl

Overview:
Sequencer for one N-stage arbiter PUF chain. It generates challenges from an LFSR and drives the chain's select bus, launch input and arbiter-flop reset. Each challenge is evaluated REPS times and reduced to one response bit by majority vote. RESP_BITS bits are accumulated into a response word behind a start/busy/done handshake.

Parameters:
N, 128, challenge width (= PUF stage count); supported values 64, 128
RESP_BITS, 32, response bits per run
REPS, 7, evaluations per challenge; must be odd, >= 1
SETTLE, 4, cycles for each of the setup phase and the race phase; >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin run; sampled only in IDLE
abort  input  1  synchronous abandon of the current run
seed  input  N  LFSR seed, loaded on accepted start
puf_sel  output  N  challenge to the PUF chain select bus
puf_in  output  1  PUF launch input; 0->1 edge starts the race
puf_reset  output  1  clears the PUF arbiter flop
puf_out  input  1  PUF arbiter output
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of a completed run
resp_valid  output  1  response holds a completed result
response  output  RESP_BITS  bit k = majority result of challenge k

Behaviour:
- Reset values: puf_sel=0, puf_in=0, puf_reset=1, busy=0, done=0, resp_valid=0, response=0. State is IDLE. Reset mid-run discards everything.
- All outputs are registered.
- FSM states: IDLE, CLEAR, SETUP, RACE, SAMPLE, DONE.
- IDLE: puf_reset=1, puf_in=0. On start=1: lfsr <= seed, or 1 if seed==0. Clear rep/ones/bit counters, response and resp_valid. Set busy=1 and go to CLEAR.
- CLEAR (1 cycle): puf_reset=1, puf_in=0, puf_sel=lfsr. Go to SETUP.
- SETUP (SETTLE cycles): puf_reset=0, puf_in=0. Lets the chain settle low. Go to RACE.
- RACE (SETTLE cycles): puf_in=1, puf_reset=0. Go to SAMPLE.
- SAMPLE (1 cycle): puf_in stays 1. Register puf_out: ones += puf_out, rep += 1.
  - If rep < REPS: go to CLEAR.
  - Else: response[bit] <= (ones_incl_this_sample >= (REPS+1)/2). Clear rep and ones, advance lfsr one step, bit += 1.
  - If bit == RESP_BITS-1: go to DONE; else go to CLEAR.
- DONE (1 cycle): done=1, resp_valid=1, busy=0, puf_reset=1. Go to IDLE. resp_valid and response then hold until the next accepted start or reset.
- One evaluation = 2*SETTLE+2 cycles. Counting the start-accept cycle as cycle 0, done is high in cycle 1 + RESP_BITS*REPS*(2*SETTLE+2). Defaults: cycle 2241.
- puf_sel changes only on CLEAR entry and is stable through SETUP, RACE and SAMPLE.
- puf_in and puf_reset are never 1 in the same cycle.
- start while busy is ignored.
- start and abort together in IDLE: abort wins; start is not accepted.
- abort in any non-IDLE state: next state IDLE, busy=0, no done pulse, resp_valid stays 0, response holds its partial contents.
- LFSR: Fibonacci, shift toward MSB, feedback into bit 0. XOR taps (1-based):
  - N=128: 128,126,101,99
  - N=64: 64,63,61,60
  - Any other N is an elaboration-time error.
- Counter widths: rep and ones use clog2(REPS+1) bits; bit uses clog2(RESP_BITS) bits. No wrap is possible within one run.

Decomposition:
- Package puf_ctrl_pkg holds:
  - the FSM state enum
  - tap constants for N=64 and N=128
  - a function lfsr_next(state, N)
  - the legal-parameter check function
- One sub-module, challenge_lfsr (ports: clk, reset, load, seed, step, q), holds the challenge register. Zero-seed substitution happens inside it.

Test Plan:
1. Assert reset 3 cycles -> all outputs at reset values (puf_reset=1, others 0). start held during reset is not accepted.
2. RESP_BITS=4, REPS=3, SETTLE=2, puf_out model tied 1, seed=0x...5 -> done pulses exactly at cycle 73, response=4'hF, resp_valid=1, busy low from cycle 73.
3. Same params; model returns per-eval sequences 1,0,1 / 0,0,1 / 1,1,0 / 0,0,0 -> response=4'b0101.
4. seed=0 -> first puf_sel=1. Each next challenge equals lfsr_next of the previous; 128-bit golden model matches over all 32 bits.
5. Mid-run abort at cycle 30, and separately reset at cycle 30 -> IDLE next cycle, busy=0, no done, resp_valid=0. A following start completes normally.
6. Protocol monitors over full default run: puf_in&puf_reset never 1; puf_sel stable while puf_in=1; puf_in 0->1 exactly 224 times; start pulses while busy are ignored.

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
// Shared types, LFSR taps and helper functions for the arbiter-PUF challenge sequencer.
package puf_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StSetup,
      StRace,
      StSample,
      StDone
   } state_e;

   // Fibonacci tap masks (bit i set means 1-based tap i+1 feeds the XOR).
   localparam logic [127:0] TapMask128 = (128'd1 << 127) | (128'd1 << 125) |
                                         (128'd1 << 100) | (128'd1 << 98);
   localparam logic [127:0] TapMask64  = (128'd1 << 63) | (128'd1 << 62) |
                                         (128'd1 << 60) | (128'd1 << 59);

   // One LFSR step for an n-bit register held in the low bits of s.
   function automatic logic [127:0] lfsr_next(input logic [127:0] s, input int unsigned n);
      logic [127:0] mask;
      logic [127:0] nxt;
      logic         fb;
      mask = (n == 64) ? TapMask64 : TapMask128;
      fb   = ^(s & mask);
      nxt  = {s[126:0], fb};
      if (n == 64) begin
         nxt[127:64] = '0;
      end
      return nxt;
   endfunction

   function automatic bit params_ok(input int unsigned n, input int unsigned reps,
                                    input int unsigned settle, input int unsigned resp_bits);
      return ((n == 64) || (n == 128)) && ((reps % 2) == 1) && (settle >= 1) &&
             (resp_bits >= 1);
   endfunction

endpackage

// File: rtl/challenge_lfsr.sv
// Challenge register: loads a seed (zero replaced by 1) and steps the Fibonacci LFSR.
module challenge_lfsr
   import puf_ctrl_pkg::*;
#(
   parameter int unsigned N = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] seed,
   input  logic         step,
   output logic [N-1:0] q
);

   logic [N-1:0] q_d, q_q;
   logic [127:0] wide;
   logic [127:0] nxt;

   // Next challenge: load has priority; an all-zero seed would lock the LFSR.
   always_comb begin
      wide         = '0;
      wide[N-1:0]  = q_q;
      nxt          = lfsr_next(wide, N);
      q_d          = q_q;
      if (load) begin
         q_d = (seed == '0) ? {{(N-1){1'b0}}, 1'b1} : seed;
      end else if (step) begin
         q_d = nxt[N-1:0];
      end
   end

   // Challenge state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF sequencer: evaluates each LFSR challenge REPS times, majority-votes a bit.
module puf_challenge_ctrl
   import puf_ctrl_pkg::*;
#(
   parameter int unsigned N         = 128,
   parameter int unsigned RESP_BITS = 32,
   parameter int unsigned REPS      = 7,
   parameter int unsigned SETTLE    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [N-1:0]         seed,
   output logic [N-1:0]         puf_sel,
   output logic                 puf_in,
   output logic                 puf_reset,
   input  logic                 puf_out,
   output logic                 busy,
   output logic                 done,
   output logic                 resp_valid,
   output logic [RESP_BITS-1:0] response
);

   localparam int unsigned RepW = $clog2(REPS + 1);
   localparam int unsigned BitW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int unsigned CntW = $clog2(SETTLE + 1);

   localparam logic [RepW-1:0] RepsL      = RepW'(REPS);
   localparam logic [RepW-1:0] MajL       = RepW'((REPS + 1) / 2);
   localparam logic [BitW-1:0] LastBit    = BitW'(RESP_BITS - 1);
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);

   if (!params_ok(N, REPS, SETTLE, RESP_BITS)) begin : g_param_err
      $error("puf_challenge_ctrl: unsupported parameter set");
   end

   state_e                state_d, state_q;
   logic [CntW-1:0]       cnt_d, cnt_q;
   logic [RepW-1:0]       rep_d, rep_q;
   logic [RepW-1:0]       ones_d, ones_q;
   logic [BitW-1:0]       bit_idx_d, bit_idx_q;
   logic [RESP_BITS-1:0]  response_d, response_q;
   logic                  resp_valid_d, resp_valid_q;
   logic                  busy_d, busy_q;
   logic                  done_d, done_q;
   logic                  puf_in_d, puf_in_q;
   logic                  puf_reset_d, puf_reset_q;
   logic                  lfsr_load, lfsr_step;
   logic [RepW-1:0]       rep_inc, ones_inc;

   assign rep_inc  = rep_q + RepW'(1);
   assign ones_inc = ones_q + RepW'(puf_out);

   challenge_lfsr #(
      .N (N)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .seed  (seed),
      .step  (lfsr_step),
      .q     (puf_sel)
   );

   // Next-state and datapath updates; outputs are decoded from the next state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rep_d        = rep_q;
      ones_d       = ones_q;
      bit_idx_d    = bit_idx_q;
      response_d   = response_q;
      resp_valid_d = resp_valid_q;
      lfsr_load    = 1'b0;
      lfsr_step    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               lfsr_load    = 1'b1;
               rep_d        = '0;
               ones_d       = '0;
               bit_idx_d    = '0;
               cnt_d        = '0;
               response_d   = '0;
               resp_valid_d = 1'b0;
               state_d      = StClear;
            end
         end
         StClear: begin
            cnt_d   = '0;
            state_d = StSetup;
         end
         StSetup: begin
            if (cnt_q == SettleLast) begin
               cnt_d   = '0;
               state_d = StRace;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRace: begin
            if (cnt_q == SettleLast) begin
               cnt_d   = '0;
               state_d = StSample;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSample: begin
            if (rep_inc < RepsL) begin
               rep_d   = rep_inc;
               ones_d  = ones_inc;
               state_d = StClear;
            end else begin
               response_d[bit_idx_q] = (ones_inc >= MajL);
               rep_d  = '0;
               ones_d = '0;
               if (bit_idx_q == LastBit) begin
                  resp_valid_d = 1'b1;
                  state_d      = StDone;
               end else begin
                  // Step only when another challenge follows, so puf_sel moves on CLEAR entry.
                  lfsr_step = 1'b1;
                  bit_idx_d = bit_idx_q + BitW'(1);
                  state_d   = StClear;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort freezes the partial result and returns to idle without a done pulse.
      if (abort && (state_q != StIdle)) begin
         state_d      = StIdle;
         response_d   = response_q;
         resp_valid_d = resp_valid_q;
         rep_d        = rep_q;
         ones_d       = ones_q;
         bit_idx_d    = bit_idx_q;
         lfsr_step    = 1'b0;
      end
   end

   // Registered output decode from the state being entered.
   always_comb begin
      puf_in_d    = 1'b0;
      puf_reset_d = 1'b1;
      unique case (state_d)
         StSetup:  puf_reset_d = 1'b0;
         StRace,
         StSample: begin
            puf_in_d    = 1'b1;
            puf_reset_d = 1'b0;
         end
         default: begin
            puf_in_d    = 1'b0;
            puf_reset_d = 1'b1;
         end
      endcase
      busy_d = (state_d == StClear) || (state_d == StSetup) || (state_d == StRace) ||
               (state_d == StSample);
      done_d = (state_d == StDone);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         rep_q        <= '0;
         ones_q       <= '0;
         bit_idx_q    <= '0;
         response_q   <= '0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         puf_in_q     <= 1'b0;
         puf_reset_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rep_q        <= rep_d;
         ones_q       <= ones_d;
         bit_idx_q    <= bit_idx_d;
         response_q   <= response_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         puf_in_q     <= puf_in_d;
         puf_reset_q  <= puf_reset_d;
      end
   end

   assign puf_in     = puf_in_q;
   assign puf_reset  = puf_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign resp_valid = resp_valid_q;
   assign response   = response_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Directed bench: a small-parameter instance for timing/vote cases, a default one for LFSR.
module tb_puf_challenge_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // Small instance: RESP_BITS=4, REPS=3, SETTLE=2.
   logic         start_a, abort_a, out_a;
   logic [127:0] seed_a, sel_a;
   logic         in_a, prst_a, busy_a, done_a, rv_a;
   logic [3:0]   resp_a;

   // Default instance.
   logic         start_b, abort_b, out_b;
   logic [127:0] seed_b, sel_b;
   logic         in_b, prst_b, busy_b, done_b, rv_b;
   logic [31:0]  resp_b;

   int n_checks = 0;
   int n_errors = 0;

   puf_challenge_ctrl #(
      .N         (128),
      .RESP_BITS (4),
      .REPS      (3),
      .SETTLE    (2)
   ) u_dut_a (
      .clk        (clk),
      .reset      (reset),
      .start      (start_a),
      .abort      (abort_a),
      .seed       (seed_a),
      .puf_sel    (sel_a),
      .puf_in     (in_a),
      .puf_reset  (prst_a),
      .puf_out    (out_a),
      .busy       (busy_a),
      .done       (done_a),
      .resp_valid (rv_a),
      .response   (resp_a)
   );

   puf_challenge_ctrl #(
      .N         (128),
      .RESP_BITS (32),
      .REPS      (7),
      .SETTLE    (4)
   ) u_dut_b (
      .clk        (clk),
      .reset      (reset),
      .start      (start_b),
      .abort      (abort_b),
      .seed       (seed_b),
      .puf_sel    (sel_b),
      .puf_in     (in_b),
      .puf_reset  (prst_b),
      .puf_out    (out_b),
      .busy       (busy_b),
      .done       (done_b),
      .resp_valid (rv_b),
      .response   (resp_b)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Golden 128-bit LFSR step with taps 128,126,101,99.
   function automatic logic [127:0] gold_step(input logic [127:0] s);
      logic fb;
      fb = s[127] ^ s[125] ^ s[100] ^ s[98];
      return {s[126:0], fb};
   endfunction

   // One run on the small instance; stop_cyc>0 aborts (or resets) during that cycle.
   task automatic run_a(input logic [0:11] pat, input int stop_cyc, input bit use_reset,
                        input logic [3:0] exp_resp, input string tag);
      int   evals    = 0;
      int   done_cyc = -1;
      int   n_done   = 0;
      logic prev_in  = 1'b0;
      @(negedge clk);
      seed_a  = 128'h5;
      start_a = 1'b1;
      abort_a = 1'b0;
      out_a   = 1'b0;
      @(posedge clk);
      for (int cyc = 1; cyc <= 90; cyc++) begin
         @(negedge clk);
         start_a = 1'b0;
         abort_a = 1'b0;
         reset   = 1'b0;
         if (in_a && !prev_in) begin
            if (evals < 12) out_a = pat[evals];
            evals++;
         end
         prev_in = in_a;
         if (done_a) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (stop_cyc == 0) begin
            if (cyc == 72) check({tag, "_busy72"}, 128'(busy_a), 128'd1);
            if (cyc == 73) begin
               check({tag, "_busy73"}, 128'(busy_a), 128'd0);
               check({tag, "_rv73"}, 128'(rv_a), 128'd1);
            end
         end else if (cyc == stop_cyc) begin
            if (use_reset) reset = 1'b1;
            else abort_a = 1'b1;
         end else if (cyc == stop_cyc + 1) begin
            check({tag, "_busy_stop"}, 128'(busy_a), 128'd0);
            check({tag, "_rv_stop"}, 128'(rv_a), 128'd0);
            check({tag, "_resp_stop"}, 128'(resp_a), 128'(exp_resp));
            check({tag, "_prst_stop"}, 128'(prst_a), 128'd1);
            check({tag, "_in_stop"}, 128'(in_a), 128'd0);
         end
      end
      if (stop_cyc == 0) begin
         check({tag, "_done_cyc"}, 128'(done_cyc), 128'd73);
         check({tag, "_n_done"}, 128'(n_done), 128'd1);
         check({tag, "_resp"}, 128'(resp_a), 128'(exp_resp));
         check({tag, "_rv_hold"}, 128'(rv_a), 128'd1);
      end else begin
         check({tag, "_no_done"}, 128'(n_done), 128'd0);
      end
   endtask

   // Full default run with seed 0, random PUF bits and protocol monitors.
   task automatic run_b();
      logic [127:0] gold     = 128'd1;
      logic [127:0] sel_hold = '0;
      logic [31:0]  exp_resp = '0;
      int           ones[32];
      int           evals    = 0;
      int           done_cyc = -1;
      int           n_done   = 0;
      int           viol     = 0;
      int           chal;
      logic         prev_in  = 1'b0;
      logic         r;
      for (int k = 0; k < 32; k++) ones[k] = 0;
      @(negedge clk);
      seed_b  = '0;
      start_b = 1'b1;
      abort_b = 1'b0;
      @(posedge clk);
      for (int cyc = 1; cyc <= 2300; cyc++) begin
         @(negedge clk);
         start_b = (cyc == 500) || (cyc == 1200);
         if (in_b && prst_b) viol++;
         if (in_b && !prev_in) begin
            chal = evals / 7;
            if ((evals % 7) == 0) begin
               check($sformatf("sel%0d", chal), sel_b, gold);
               gold = gold_step(gold);
            end
            sel_hold = sel_b;
            r        = 1'($urandom_range(0, 1));
            out_b    = r;
            if (chal < 32) ones[chal] += int'(r);
            evals++;
         end else if (in_b && (sel_b !== sel_hold)) begin
            viol++;
         end
         prev_in = in_b;
         if (done_b) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
      end
      for (int k = 0; k < 32; k++) exp_resp[k] = (ones[k] >= 4);
      check("b_done_cyc", 128'(done_cyc), 128'd2241);
      check("b_n_done", 128'(n_done), 128'd1);
      check("b_launches", 128'(evals), 128'd224);
      check("b_protocol", 128'(viol), 128'd0);
      check("b_resp", 128'(resp_b), 128'(exp_resp));
      check("b_rv", 128'(rv_b), 128'd1);
      check("b_busy", 128'(busy_b), 128'd0);
   endtask

   initial begin
      reset   = 1'b1;
      start_a = 1'b1;
      start_b = 1'b1;
      abort_a = 1'b0;
      abort_b = 1'b0;
      seed_a  = 128'h5;
      seed_b  = '0;
      out_a   = 1'b0;
      out_b   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sel", sel_a, 128'd0);
      check("rst_in", 128'(in_a), 128'd0);
      check("rst_prst", 128'(prst_a), 128'd1);
      check("rst_busy", 128'(busy_a), 128'd0);
      check("rst_done", 128'(done_a), 128'd0);
      check("rst_rv", 128'(rv_a), 128'd0);
      check("rst_resp", 128'(resp_a), 128'd0);
      check("rst_busy_b", 128'(busy_b), 128'd0);
      reset   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 128'(busy_a), 128'd0);

      // start together with abort in idle is not accepted
      start_a = 1'b1;
      abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      check("start_abort_busy", 128'(busy_a), 128'd0);

      run_a(12'b111111111111, 0, 1'b0, 4'hF, "tied1");
      run_a(12'b101001110000, 0, 1'b0, 4'b0101, "votes");
      run_a(12'b111111111111, 30, 1'b0, 4'b0001, "abort");
      run_a(12'b111111111111, 0, 1'b0, 4'hF, "after_abort");
      run_a(12'b111111111111, 30, 1'b1, 4'h0, "reset");
      check("reset_sel", sel_a, 128'd0);
      run_a(12'b111111111111, 0, 1'b0, 4'hF, "after_reset");
      run_b();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
